// File: rtl/mem_resp_pkg.sv
// Shared types and limits for the MEM-stage data memory responder.
// Holds the read FSM encoding and the read-latency counter sizing.
package mem_resp_pkg;

   localparam int unsigned MAX_READ_LATENCY = 4;
   localparam int unsigned CNT_WIDTH        = $clog2(MAX_READ_LATENCY);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StWait  = 2'd1,
      StReady = 2'd2
   } state_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// MEM-stage memory port between the datapath (master) and the data memory (slave).
interface data_mem_responder_if;

   logic        mem_ren;
   logic        mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_dout;
   logic        mem_adv;
   logic [31:0] mem_din;
   logic        mem_stall;
   logic        mem_err;
   logic [31:0] err_addr;

   modport master (
      output mem_ren, mem_wen, mem_addr, mem_dout, mem_adv,
      input  mem_din, mem_stall, mem_err, err_addr
   );

   modport slave (
      input  mem_ren, mem_wen, mem_addr, mem_dout, mem_adv,
      output mem_din, mem_stall, mem_err, err_addr
   );

endinterface

// File: rtl/sync_ram.sv
// Single-port word RAM: writes land at the edge, reads pass through a register pipeline.
// A read launched in cycle T shows rdata/rvalid in cycle T+LATENCY-1; the consumer's
// capture register is the final pipeline stage.
module sync_ram #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned LATENCY    = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic                  ren,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata,
   output logic                  rvalid
);

   logic [31:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   if (LATENCY <= 1) begin : g_direct
      assign rdata  = mem[addr];
      assign rvalid = ren;
   end else begin : g_pipe
      logic [31:0]        data_q [LATENCY-1];
      logic [LATENCY-2:0] valid_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < int'(LATENCY) - 1; i++) begin
               data_q[i] <= '0;
            end
            valid_q <= '0;
         end else begin
            data_q[0]  <= mem[addr];
            valid_q[0] <= ren;
            for (int i = 1; i < int'(LATENCY) - 1; i++) begin
               data_q[i]  <= data_q[i-1];
               valid_q[i] <= valid_q[i-1];
            end
         end
      end

      assign rdata  = data_q[LATENCY-2];
      assign rvalid = valid_q[LATENCY-2];
   end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM stage: single-cycle writes, stalled multi-cycle reads,
// and a sticky fault flag with the first faulting address.
module data_mem_responder
   import mem_resp_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = 10,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
   parameter int unsigned READ_LATENCY = 2
) (
   input logic                 clk,
   input logic                 rst_n,
   data_mem_responder_if.slave bus
);

   if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
      $error("READ_LATENCY out of range");
   end

   localparam logic [32:0] RANGE_BYTES = 33'd4 << ADDR_WIDTH;

   state_t                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic [31:0]            rdata_q, rdata_d;
   logic                   err_q, err_d;
   logic [31:0]            err_addr_q, err_addr_d;

   logic [31:0]            offset;
   logic                   in_range;
   logic                   is_idle;
   logic                   fault;
   logic                   launch;
   logic                   ram_we;
   logic [31:0]            ram_rdata;
   logic                   ram_rvalid;
   logic                   stall;
   logic [31:0]            din;

   // Offset compare on 33 bits so addresses below BASE_ADDR wrap to out-of-range.
   assign offset   = bus.mem_addr - BASE_ADDR;
   assign in_range = ({1'b0, offset} < RANGE_BYTES) && (bus.mem_addr[1:0] == 2'b00);

   assign is_idle = (state_q == StIdle);
   assign fault   = is_idle && (bus.mem_ren || bus.mem_wen) &&
                    ((bus.mem_ren && bus.mem_wen) || !in_range);
   assign launch  = is_idle && bus.mem_ren && !bus.mem_wen && in_range;
   assign ram_we  = is_idle && bus.mem_wen && !bus.mem_ren && in_range;

   sync_ram #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .LATENCY    (READ_LATENCY)
   ) u_ram (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (ram_we),
      .ren    (launch),
      .addr   (offset[ADDR_WIDTH+1:2]),
      .wdata  (bus.mem_dout),
      .rdata  (ram_rdata),
      .rvalid (ram_rvalid)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      stall   = 1'b0;
      din     = '0;
      unique case (state_q)
         StIdle: begin
            if (launch) begin
               stall = 1'b1;
               if (READ_LATENCY == 1) begin
                  rdata_d = ram_rdata;
                  state_d = StReady;
               end else begin
                  cnt_d   = CNT_WIDTH'(READ_LATENCY - 1);
                  state_d = StWait;
               end
            end
         end
         StWait: begin
            stall = 1'b1;
            cnt_d = cnt_q - 1'b1;
            if (cnt_d == '0 && ram_rvalid) begin
               rdata_d = ram_rdata;
               state_d = StReady;
            end
         end
         StReady: begin
            din = rdata_q;
            if (bus.mem_adv) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign err_d      = err_q | fault;
   assign err_addr_d = (fault && !err_q) ? bus.mem_addr : err_addr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         err_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
         err_addr_q <= err_addr_d;
      end
   end

   assign bus.mem_din   = din;
   assign bus.mem_stall = stall;
   assign bus.mem_err   = err_q;
   assign bus.err_addr  = err_addr_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (READ_LATENCY=2, base 0, 1K words).
module tb_data_mem_responder;

   logic clk;
   logic rst_n;
   int   n_pass;
   int   n_total;

   data_mem_responder_if bus ();

   data_mem_responder #(
      .ADDR_WIDTH   (10),
      .BASE_ADDR    (32'h0000_0000),
      .READ_LATENCY (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n        = 1'b0;
      bus.mem_ren  = 1'b0;
      bus.mem_wen  = 1'b0;
      bus.mem_addr = '0;
      bus.mem_dout = '0;
      bus.mem_adv  = 1'b0;
      step();
      step();
      mid();
      n_total++;
      if (bus.mem_din !== 32'h0) $display("FAIL rst_din: got %h, expected 0", bus.mem_din);
      else n_pass++;
      n_total++;
      if (bus.mem_stall !== 1'b0) $display("FAIL rst_stall: got %b, expected 0", bus.mem_stall);
      else n_pass++;
      n_total++;
      if (bus.mem_err !== 1'b0) $display("FAIL rst_err: got %b, expected 0", bus.mem_err);
      else n_pass++;
      n_total++;
      if (bus.err_addr !== 32'h0) $display("FAIL rst_err_addr: got %h, expected 0", bus.err_addr);
      else n_pass++;
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_write_read_hold();
      step();
      bus.mem_wen  = 1'b1;
      bus.mem_addr = 32'h0000_0010;
      bus.mem_dout = 32'h1234_5678;
      mid();
      n_total++;
      if (bus.mem_stall !== 1'b0) $display("FAIL wr_stall: got %b, expected 0", bus.mem_stall);
      else n_pass++;
      step();
      bus.mem_wen = 1'b0;
      bus.mem_ren = 1'b1;
      mid();
      n_total++;
      if (bus.mem_stall !== 1'b1) $display("FAIL rd_stall_t0: got %b, expected 1", bus.mem_stall);
      else n_pass++;
      n_total++;
      if (bus.mem_din !== 32'h0) $display("FAIL rd_din_t0: got %h, expected 0", bus.mem_din);
      else n_pass++;
      step();
      mid();
      n_total++;
      if (bus.mem_stall !== 1'b1) $display("FAIL rd_stall_t1: got %b, expected 1", bus.mem_stall);
      else n_pass++;
      n_total++;
      if (bus.mem_din !== 32'h0) $display("FAIL rd_din_t1: got %h, expected 0", bus.mem_din);
      else n_pass++;
      for (int k = 0; k < 3; k++) begin
         step();
         mid();
         n_total++;
         if (bus.mem_stall !== 1'b0)
            $display("FAIL hold_stall[%0d]: got %b, expected 0", k, bus.mem_stall);
         else n_pass++;
         n_total++;
         if (bus.mem_din !== 32'h1234_5678)
            $display("FAIL hold_din[%0d]: got %h, expected 12345678", k, bus.mem_din);
         else n_pass++;
      end
      step();
      bus.mem_adv = 1'b1;
      mid();
      n_total++;
      if (bus.mem_din !== 32'h1234_5678) $display("FAIL adv_din: got %h, expected 12345678", bus.mem_din);
      else n_pass++;
      step();
      bus.mem_ren = 1'b0;
      bus.mem_adv = 1'b0;
      mid();
      n_total++;
      if (bus.mem_din !== 32'h0) $display("FAIL idle_din: got %h, expected 0", bus.mem_din);
      else n_pass++;
      n_total++;
      if (bus.mem_stall !== 1'b0) $display("FAIL idle_stall: got %b, expected 0", bus.mem_stall);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      step();
      bus.mem_wen  = 1'b1;
      bus.mem_addr = 32'h0000_0014;
      bus.mem_dout = 32'hAAAA_0001;
      step();
      bus.mem_wen  = 1'b0;
      bus.mem_ren  = 1'b1;
      bus.mem_addr = 32'h0000_0010;
      mid();
      n_total++;
      if (bus.mem_stall !== 1'b1) $display("FAIL b2b_a_stall0: got %b, expected 1", bus.mem_stall);
      else n_pass++;
      step();
      mid();
      n_total++;
      if (bus.mem_stall !== 1'b1) $display("FAIL b2b_a_stall1: got %b, expected 1", bus.mem_stall);
      else n_pass++;
      step();
      bus.mem_adv = 1'b1;
      mid();
      n_total++;
      if (bus.mem_stall !== 1'b0) $display("FAIL b2b_a_ready_stall: got %b, expected 0", bus.mem_stall);
      else n_pass++;
      n_total++;
      if (bus.mem_din !== 32'h1234_5678) $display("FAIL b2b_a_din: got %h, expected 12345678", bus.mem_din);
      else n_pass++;
      step();
      bus.mem_adv  = 1'b0;
      bus.mem_addr = 32'h0000_0014;
      mid();
      n_total++;
      if (bus.mem_stall !== 1'b1) $display("FAIL b2b_b_stall0: got %b, expected 1", bus.mem_stall);
      else n_pass++;
      n_total++;
      if (bus.mem_din !== 32'h0) $display("FAIL b2b_b_din0: got %h, expected 0", bus.mem_din);
      else n_pass++;
      step();
      mid();
      n_total++;
      if (bus.mem_stall !== 1'b1) $display("FAIL b2b_b_stall1: got %b, expected 1", bus.mem_stall);
      else n_pass++;
      step();
      bus.mem_adv = 1'b1;
      mid();
      n_total++;
      if (bus.mem_stall !== 1'b0) $display("FAIL b2b_b_ready_stall: got %b, expected 0", bus.mem_stall);
      else n_pass++;
      n_total++;
      if (bus.mem_din !== 32'hAAAA_0001) $display("FAIL b2b_b_din: got %h, expected aaaa0001", bus.mem_din);
      else n_pass++;
      step();
      bus.mem_ren = 1'b0;
      bus.mem_adv = 1'b0;
   endtask

   task automatic test_fault();
      step();
      bus.mem_ren  = 1'b1;
      bus.mem_addr = 32'h0000_0002;
      mid();
      n_total++;
      if (bus.mem_stall !== 1'b0) $display("FAIL unalign_stall: got %b, expected 0", bus.mem_stall);
      else n_pass++;
      n_total++;
      if (bus.mem_din !== 32'h0) $display("FAIL unalign_din: got %h, expected 0", bus.mem_din);
      else n_pass++;
      n_total++;
      if (bus.mem_err !== 1'b0) $display("FAIL unalign_err_early: got %b, expected 0", bus.mem_err);
      else n_pass++;
      step();
      bus.mem_ren = 1'b0;
      mid();
      n_total++;
      if (bus.mem_err !== 1'b1) $display("FAIL unalign_err: got %b, expected 1", bus.mem_err);
      else n_pass++;
      n_total++;
      if (bus.err_addr !== 32'h2) $display("FAIL unalign_err_addr: got %h, expected 2", bus.err_addr);
      else n_pass++;
      step();
      bus.mem_ren  = 1'b1;
      bus.mem_addr = 32'hFFFF_FFF0;
      mid();
      n_total++;
      if (bus.mem_stall !== 1'b0) $display("FAIL oor_stall: got %b, expected 0", bus.mem_stall);
      else n_pass++;
      step();
      bus.mem_ren = 1'b0;
      mid();
      n_total++;
      if (bus.err_addr !== 32'h2) $display("FAIL oor_err_addr_kept: got %h, expected 2", bus.err_addr);
      else n_pass++;
      n_total++;
      if (bus.mem_err !== 1'b1) $display("FAIL oor_err_sticky: got %b, expected 1", bus.mem_err);
      else n_pass++;
   endtask

   task automatic test_conflict();
      step();
      bus.mem_wen  = 1'b1;
      bus.mem_addr = 32'h0000_0020;
      bus.mem_dout = 32'h55AA_55AA;
      step();
      bus.mem_wen = 1'b0;
      rst_n       = 1'b0;
      mid();
      n_total++;
      if (bus.mem_err !== 1'b0) $display("FAIL rst_clears_err: got %b, expected 0", bus.mem_err);
      else n_pass++;
      step();
      rst_n = 1'b1;
      step();
      bus.mem_ren  = 1'b1;
      bus.mem_wen  = 1'b1;
      bus.mem_dout = 32'hDEAD_BEEF;
      mid();
      n_total++;
      if (bus.mem_stall !== 1'b0) $display("FAIL rw_stall: got %b, expected 0", bus.mem_stall);
      else n_pass++;
      step();
      bus.mem_ren = 1'b0;
      bus.mem_wen = 1'b0;
      mid();
      n_total++;
      if (bus.mem_err !== 1'b1) $display("FAIL rw_err: got %b, expected 1", bus.mem_err);
      else n_pass++;
      n_total++;
      if (bus.err_addr !== 32'h20) $display("FAIL rw_err_addr: got %h, expected 20", bus.err_addr);
      else n_pass++;
      step();
      bus.mem_ren = 1'b1;
      step();
      step();
      bus.mem_adv = 1'b1;
      mid();
      n_total++;
      if (bus.mem_din !== 32'h55AA_55AA) $display("FAIL rw_no_write: got %h, expected 55aa55aa", bus.mem_din);
      else n_pass++;
      step();
      bus.mem_ren = 1'b0;
      bus.mem_adv = 1'b0;
   endtask

   task automatic test_reset_mid_read();
      step();
      bus.mem_ren  = 1'b1;
      bus.mem_addr = 32'h0000_0010;
      step();
      mid();
      n_total++;
      if (bus.mem_stall !== 1'b1) $display("FAIL abort_pre_stall: got %b, expected 1", bus.mem_stall);
      else n_pass++;
      #1;
      rst_n       = 1'b0;
      bus.mem_ren = 1'b0;
      #1;
      n_total++;
      if (bus.mem_stall !== 1'b0) $display("FAIL abort_stall: got %b, expected 0", bus.mem_stall);
      else n_pass++;
      n_total++;
      if (bus.mem_din !== 32'h0) $display("FAIL abort_din: got %h, expected 0", bus.mem_din);
      else n_pass++;
      step();
      rst_n = 1'b1;
      step();
      bus.mem_ren = 1'b1;
      mid();
      n_total++;
      if (bus.mem_stall !== 1'b1) $display("FAIL rerd_stall0: got %b, expected 1", bus.mem_stall);
      else n_pass++;
      step();
      mid();
      n_total++;
      if (bus.mem_stall !== 1'b1) $display("FAIL rerd_stall1: got %b, expected 1", bus.mem_stall);
      else n_pass++;
      step();
      bus.mem_adv = 1'b1;
      mid();
      n_total++;
      if (bus.mem_stall !== 1'b0) $display("FAIL rerd_ready_stall: got %b, expected 0", bus.mem_stall);
      else n_pass++;
      n_total++;
      if (bus.mem_din !== 32'h1234_5678) $display("FAIL rerd_din: got %h, expected 12345678", bus.mem_din);
      else n_pass++;
      step();
      bus.mem_ren = 1'b0;
      bus.mem_adv = 1'b0;
      mid();
      n_total++;
      if (bus.mem_din !== 32'h0) $display("FAIL rerd_idle_din: got %h, expected 0", bus.mem_din);
      else n_pass++;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      test_reset();
      test_write_read_hold();
      test_back_to_back();
      test_fault();
      test_conflict();
      test_reset_mid_read();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
